// File: rtl/spi_cmd_tx.sv
// rtl/spi_cmd_tx.sv - SPI mode-0 initiator: queues {cmd, data} packets and shifts them out MSB first.
module spi_cmd_tx #(
  parameter int PACKET_WIDTH = 24,
  parameter int DATA_WIDTH   = PACKET_WIDTH - 8,
  parameter int CLK_DIV      = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [7:0]                    in_cmd,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          done,
  output logic                          sclk,
  output logic                          mosi,
  output logic                          csb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(PACKET_WIDTH);
  localparam logic [7:0]    CNT_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PACKET_WIDTH - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PACKET_WIDTH-1:0] shift_reg;
  logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             level_next;
  logic                    push;
  logic                    pop;
  logic                    cnt_last;

  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_level != '0);
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + (AW + 1)'(1);
    else if (!push && pop)
      level_next = fifo_level - (AW + 1)'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= {in_cmd, in_data};
  end

  // in_ready looks only at the next level, so a same-cycle pop never gates a push.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      in_ready   <= (level_next != LEVEL_FULL);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      csb       <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || cnt_last)
        cnt <= '0;
      else
        cnt <= cnt + 8'd1;
      case (state)
        IDLE: begin
          if (pop) begin
            mosi      <= mem[rd_ptr][PACKET_WIDTH-1];
            shift_reg <= {mem[rd_ptr][PACKET_WIDTH-2:0], 1'b0};
            csb       <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end else begin
            busy <= (level_next != '0);
          end
        end
        SETUP, LOW: begin
          if (cnt_last) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_last) begin
            sclk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              // Next bit goes out together with the falling edge.
              mosi      <= shift_reg[PACKET_WIDTH-1];
              shift_reg <= {shift_reg[PACKET_WIDTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + BW'(1);
              state     <= LOW;
            end
          end
        end
        HOLD: begin
          if (cnt_last) begin
            csb   <= 1'b1;
            mosi  <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt_last) begin
            busy  <= (level_next != '0);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
